// File: rtl/pipelined_barrel_rotator.sv
// Pipelined logarithmic barrel rotator: stage k rotates by 2**k when its amount bit is set.
// A single global advance signal moves every stage together, so the pipe stalls as one unit.
module pipelined_barrel_rotator #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    input  logic          in_dir,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data
);

    // Index 0 is the upstream interface, index k+1 is the register of stage k.
    logic [N-1:0]  src_data [AW+1];
    logic [AW-1:0] src_amt  [AW+1];
    logic [AW:0]   src_valid;
    logic [AW:0]   src_dir;
    logic          adv;
    logic          unused_tail;

    assign src_data[0]  = in_data;
    assign src_amt[0]   = in_amt;
    assign src_valid[0] = in_valid;
    assign src_dir[0]   = in_dir;

    assign adv       = !src_valid[AW] | out_ready;
    assign in_ready  = adv;
    assign out_valid = src_valid[AW];
    assign out_data  = src_data[AW];

    // The last stage's leftover amount and direction have no consumer.
    assign unused_tail = ^{src_amt[AW], src_dir[AW]};

    genvar gi;
    generate
        for (gi = 0; gi < AW; gi++) begin : g_stage
            localparam int SH = 1 << gi;

            logic [N-1:0]  rot_l;
            logic [N-1:0]  rot_r;
            logic [N-1:0]  data_next;
            logic [N-1:0]  data_reg;
            logic [AW-1:0] amt_reg;
            logic          valid_reg;
            logic          dir_reg;

            assign rot_l = {src_data[gi][N-SH-1:0], src_data[gi][N-1:N-SH]};
            assign rot_r = {src_data[gi][SH-1:0], src_data[gi][N-1:SH]};

            // The amount travels shifted down so bit 0 always belongs to the current stage.
            always_comb begin
                data_next = src_data[gi];
                if (src_amt[gi][0]) begin
                    data_next = src_dir[gi] ? rot_r : rot_l;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    amt_reg   <= '0;
                    dir_reg   <= 1'b0;
                end else if (adv) begin
                    valid_reg <= src_valid[gi];
                    data_reg  <= data_next;
                    amt_reg   <= src_amt[gi] >> 1;
                    dir_reg   <= src_dir[gi];
                end
            end

            assign src_valid[gi+1] = valid_reg;
            assign src_data[gi+1]  = data_reg;
            assign src_amt[gi+1]   = amt_reg;
            assign src_dir[gi+1]   = dir_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// Scoreboard bench for pipelined_barrel_rotator: N=8 directed scenarios plus an N=2/4/16/32 sweep.
module tb_pipelined_barrel_rotator;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_data = '0;
    logic [AW-1:0] in_amt = '0;
    logic          in_dir = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_data;

    always #5 clk = ~clk;

    pipelined_barrel_rotator #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // Sweep instances, widths 2, 4, 16, 32.
    logic [3:0]  sw_valid = '0;
    logic [3:0]  sw_dir = '0;
    logic [3:0]  sw_ordy = '1;
    logic [31:0] sw_data [4];
    logic [4:0]  sw_amt [4];
    logic [3:0]  sw_irdy;
    logic [3:0]  sw_ov;
    logic [31:0] sw_od [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sweep
            localparam int NI  = (gi == 0) ? 2 : (gi == 1) ? 4 : (gi == 2) ? 16 : 32;
            localparam int AWI = $clog2(NI);
            logic          irdy;
            logic          ov;
            logic [NI-1:0] od;
            pipelined_barrel_rotator #(.N(NI)) u_dut (
                .clk(clk), .rst_n(rst_n),
                .in_valid(sw_valid[gi]), .in_ready(irdy),
                .in_data(sw_data[gi][NI-1:0]), .in_amt(sw_amt[gi][AWI-1:0]),
                .in_dir(sw_dir[gi]),
                .out_valid(ov), .out_ready(sw_ordy[gi]), .out_data(od)
            );
            assign sw_irdy[gi] = irdy;
            assign sw_ov[gi]   = ov;
            assign sw_od[gi]   = 32'(od);
        end
    endgenerate

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          obs_cyc;
    logic        obs_valid;
    logic        obs_ready;
    logic [N-1:0] obs_data;
    logic        fired;
    logic [31:0] sb [$];
    logic [31:0] exp_v;

    function automatic logic [31:0] rot_ref(input logic [31:0] a, input int s, input logic dr, input int n);
        logic [63:0] m;
        logic [63:0] x;
        logic [63:0] r;
        m = (64'd1 << n) - 64'd1;
        x = {32'd0, a} & m;
        if (!dr) r = ((x << s) | (x >> (n - s))) & m;
        else     r = ((x >> s) | (x << (n - s))) & m;
        return r[31:0];
    endfunction

    // Drives one cycle on the N=8 instance, records the scoreboard entry on acceptance,
    // and returns what the DUT showed during that cycle.
    task automatic step(input logic v, input logic [N-1:0] d, input logic [AW-1:0] a,
                        input logic dr, input logic ordy, input logic [N-1:0] exp);
        in_valid  = v;
        in_data   = d;
        in_amt    = a;
        in_dir    = dr;
        out_ready = ordy;
        #1;
        fired = in_valid && in_ready;
        if (fired) sb.push_back(32'(exp));
        obs_valid = out_valid;
        obs_data  = out_data;
        obs_ready = in_ready;
        obs_cyc   = cyc;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        $display("reset done");
    endtask

    task automatic test_single();
        int acc;
        int pulses;
        pulses = 0;
        step(1'b1, 8'hA3, 3'd3, 1'b0, 1'b1, 8'h1D);
        acc = obs_cyc;
        checks++;
        if (fired !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", fired); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h00);
            if (obs_valid) begin
                pulses++;
                checks++;
                if (obs_cyc != acc + 3) begin errors++; $display("FAIL single_latency got %0d want %0d", obs_cyc - acc, 3); end
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL single_data unexpected output %h", obs_data); end
                else begin
                    exp_v = sb.pop_front();
                    if (32'(obs_data) !== exp_v) begin errors++; $display("FAIL single_data got %h want %h", obs_data, exp_v[7:0]); end
                    else $display("single out=%h", obs_data);
                end
            end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_rotations();
        logic [7:0] td [4];
        logic [2:0] ta [4];
        logic       tr [4];
        logic [7:0] te [4];
        int         got;
        td = '{8'hA3, 8'hA3, 8'hA3, 8'h81};
        ta = '{3'd3, 3'd0, 3'd0, 3'd7};
        tr = '{1'b1, 1'b0, 1'b1, 1'b0};
        te = '{8'h74, 8'hA3, 8'hA3, 8'hC0};
        got = 0;
        for (int j = 0; j < 10; j++) begin
            if (j < 4) step(1'b1, td[j], ta[j], tr[j], 1'b1, te[j]);
            else       step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h00);
            if (obs_valid) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL rot_data unexpected output %h", obs_data); end
                else begin
                    exp_v = sb.pop_front();
                    if (32'(obs_data) !== exp_v) begin errors++; $display("FAIL rot_data got %h want %h", obs_data, exp_v[7:0]); end
                    else $display("rot out=%h", obs_data);
                end
                got++;
            end
        end
        checks++;
        if (got != 4) begin errors++; $display("FAIL rot_count got %0d want 4", got); end
    endtask

    task automatic test_stream();
        int prev;
        int got;
        prev = -1;
        got = 0;
        for (int j = 0; j < 13; j++) begin
            if (j < 8) step(1'b1, 8'h01, 3'(j), 1'b0, 1'b1, 8'(1 << j));
            else       step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h00);
            if (obs_valid) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL stream_data unexpected output %h", obs_data); end
                else begin
                    exp_v = sb.pop_front();
                    if (32'(obs_data) !== exp_v) begin errors++; $display("FAIL stream_data got %h want %h", obs_data, exp_v[7:0]); end
                    else $display("stream out=%h", obs_data);
                end
                if (prev >= 0) begin
                    checks++;
                    if (obs_cyc != prev + 1) begin errors++; $display("FAIL stream_gap got %0d want 1", obs_cyc - prev); end
                end
                prev = obs_cyc;
                got++;
            end
        end
        checks++;
        if (got != 8) begin errors++; $display("FAIL stream_count got %0d want 8", got); end
    endtask

    task automatic test_backpressure();
        int         idx;
        int         got;
        logic       ordy;
        logic       held;
        logic [7:0] held_data;
        logic [7:0] d;
        logic [2:0] a;
        logic       r;
        idx = 0;
        got = 0;
        held = 1'b0;
        held_data = '0;
        d = 8'($urandom);
        a = 3'($urandom_range(0, 7));
        r = 1'($urandom_range(0, 1));
        for (int c = 0; c < 20; c++) begin
            ordy = !(c >= 4 && c < 8);
            step(idx < 5, d, a, r, ordy, 8'(rot_ref(32'(d), int'(a), r, 8)));
            if (fired) begin
                idx++;
                d = 8'($urandom);
                a = 3'($urandom_range(0, 7));
                r = 1'($urandom_range(0, 1));
            end
            if (!ordy && obs_valid) begin
                checks++;
                if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", obs_ready); end
                if (held) begin
                    checks++;
                    if (obs_data !== held_data) begin errors++; $display("FAIL bp_stable got %h want %h", obs_data, held_data); end
                end
                held = 1'b1;
                held_data = obs_data;
            end
            if (ordy && obs_valid) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL bp_data unexpected output %h", obs_data); end
                else begin
                    exp_v = sb.pop_front();
                    if (32'(obs_data) !== exp_v) begin errors++; $display("FAIL bp_data got %h want %h", obs_data, exp_v[7:0]); end
                    else $display("bp out=%h", obs_data);
                end
                got++;
            end
        end
        checks++;
        if (got != 5 || !held) begin errors++; $display("FAIL bp_count got %0d stalled %b want 5 stalled 1", got, held); end
    endtask

    task automatic test_bubbles();
        logic       vs [12];
        logic       ovs [12];
        logic [7:0] d;
        logic [2:0] a;
        logic       r;
        for (int c = 0; c < 12; c++) begin
            vs[c] = (c < 4) && (c % 2 == 0);
            d = 8'($urandom);
            a = 3'($urandom_range(0, 7));
            r = 1'($urandom_range(0, 1));
            step(vs[c], d, a, r, 1'b1, 8'(rot_ref(32'(d), int'(a), r, 8)));
            ovs[c] = obs_valid;
            if (obs_valid) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL bub_data unexpected output %h", obs_data); end
                else begin
                    exp_v = sb.pop_front();
                    if (32'(obs_data) !== exp_v) begin errors++; $display("FAIL bub_data got %h want %h", obs_data, exp_v[7:0]); end
                    else $display("bubble out=%h", obs_data);
                end
            end
        end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (ovs[c+3] !== vs[c]) begin errors++; $display("FAIL bub_pattern cycle %0d got %b want %b", c + 3, ovs[c+3], vs[c]); end
        end
    endtask

    task automatic test_reset_mid();
        int stale;
        int acc;
        stale = 0;
        for (int j = 0; j < 3; j++) step(1'b1, 8'(8'h11 << j), 3'(j + 1), 1'b0, 1'b0, 8'h00);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        #1;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL rmid_out_data got %h want 00", out_data); end
        for (int j = 0; j < 5; j++) begin
            step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h00);
            if (obs_valid) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL rmid_stale got %0d want 0", stale); end
        step(1'b1, 8'h5A, 3'd1, 1'b1, 1'b1, 8'h2D);
        acc = obs_cyc;
        for (int j = 0; j < 6; j++) begin
            step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h00);
            if (obs_valid) begin
                checks++;
                if (obs_cyc != acc + 3) begin errors++; $display("FAIL rmid_latency got %0d want 3", obs_cyc - acc); end
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL rmid_data unexpected output %h", obs_data); end
                else begin
                    exp_v = sb.pop_front();
                    if (32'(obs_data) !== exp_v) begin errors++; $display("FAIL rmid_data got %h want %h", obs_data, exp_v[7:0]); end
                    else $display("rmid out=%h", obs_data);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL rmid_drain got %0d left want 0", sb.size()); end
    endtask

    task automatic test_sweep();
        int widths [4];
        int n;
        int got;
        widths = '{2, 4, 16, 32};
        for (int i = 0; i < 4; i++) begin
            n = widths[i];
            got = 0;
            for (int c = 0; c < 50; c++) begin
                sw_valid = '0;
                sw_ordy = '1;
                sw_valid[i] = (c < 30);
                sw_data[i] = $urandom;
                sw_amt[i] = 5'($urandom_range(0, n - 1));
                sw_dir[i] = 1'($urandom_range(0, 1));
                sw_ordy[i] = ($urandom_range(0, 3) != 0);
                #1;
                if (sw_valid[i] && sw_irdy[i]) sb.push_back(rot_ref(sw_data[i], int'(sw_amt[i]), sw_dir[i], n));
                if (sw_ov[i] && sw_ordy[i]) begin
                    checks++;
                    if (sb.size() == 0) begin errors++; $display("FAIL sweep_n%0d unexpected output %h", n, sw_od[i]); end
                    else begin
                        exp_v = sb.pop_front();
                        if (sw_od[i] !== exp_v) begin errors++; $display("FAIL sweep_n%0d got %h want %h", n, sw_od[i], exp_v); end
                        else $display("sweep n=%0d out=%h", n, sw_od[i]);
                    end
                    got++;
                end
                @(posedge clk);
                @(negedge clk);
            end
            sw_valid = '0;
            sw_ordy = '1;
            checks++;
            if (sb.size() != 0 || got == 0) begin errors++; $display("FAIL sweep_n%0d_drain left %0d got %0d want 0 left", n, sb.size(), got); end
            sb.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            sw_data[i] = '0;
            sw_amt[i] = '0;
        end
        test_reset();
        test_single();
        test_rotations();
        test_stream();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipelined_barrel_rotator.md
Name: pipelined_barrel_rotator

Overview:
- Variable-amount, variable-direction circular rotator for N-bit words.
- Logarithmic barrel structure with one register stage per shift-amount bit.
- Uses valid/ready handshakes on both sides. It sits between an operand-producing stage and downstream arithmetic, and replaces fixed-S rotate logic where S varies per word.
- Stage k rotates by 2^k when amount bit k is set, giving $clog2(N) cycles of latency at full throughput.

Parameters:
- N, default 8: data width. Must be a power of two and ≥ 2.
- AW, default $clog2(N): width of the rotate-amount field. Derived; not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  N  word to rotate.
- in_amt  input  AW  rotate amount, 0..N-1.
- in_dir  input  1  0 = rotate left, 1 = rotate right.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_data  output  N  rotated word.

Behaviour:
- Structure: AW stages, numbered 0..AW-1. Each stage register holds:
  - valid bit
  - N-bit data
  - remaining amount bits
  - dir
- Stage k operation: if amt[k]=1, rotate by 2^k (left if dir=0, right if dir=1); otherwise pass data unchanged.
- Stage 0 consumes in_*; stage AW-1 drives out_*.
- Arithmetic: rotation is exact modulo N, with no bits lost. Rotate-left by s equals rotate-right by N-s.
  - amt=0 returns in_data unchanged in either direction.
- Advance rule (global stall): adv = !out_valid | out_ready.
  - When adv=1, every stage loads from its predecessor, including its valid bit.
  - When adv=0, all stages hold their contents.
- in_ready = adv. This is combinational from out_valid and out_ready; no combinational path exists from in_valid to in_ready.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - When in_valid=0 and adv=1, a bubble (valid=0) enters stage 0.
  - Output transfer occurs when out_valid & out_ready.
- Latency: a word accepted in cycle t appears with out_valid=1 in cycle t+AW, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one word per cycle when out_ready is held at 1.
- Ordering: words leave strictly in acceptance order; none are dropped or duplicated.
- Backpressure: while out_valid=1 and out_ready=0, out_data stays stable and in_ready=0.
  - Upstream must keep in_data, in_amt and in_dir stable until accepted.
  - The block itself does not depend on that, because it samples only on transfer.
- Simultaneous events: when out_ready=1 and in_valid=1 in the same cycle with a full pipeline, the output word leaves and the new word enters in that same cycle.
- Reset (rst_n=0 at a clock edge):
  - All stage valid bits, and therefore out_valid, go to 0.
  - All data registers go to 0, so out_data=0.
  - in_ready reads 1 in the first cycle after reset.
- Reset mid-operation discards every in-flight word without producing output. The first accepted word after reset appears AW cycles later.
- Out-of-range amounts cannot occur, since AW bits encode exactly 0..N-1.
- N=2 degenerates to a single stage with latency 1.

Test Plan:
- Reset then single word: N=8, in_data=0xA3, in_amt=3, in_dir=0 → out_data=0x1D, out_valid exactly 3 cycles after acceptance, a single-cycle pulse with out_ready=1.
- Right rotate and identity: 0xA3 with amt=3 dir=1 → 0x74; 0xA3 with amt=0 in either dir → 0xA3; 0x81 with amt=7 dir=0 → 0xC0.
- Streaming with out_ready=1: send 0x01 left by amt 0..7 on consecutive cycles → outputs 0x01,0x02,0x04,…,0x80 on 8 consecutive cycles, in order, no gaps.
- Backpressure: stream 5 words, hold out_ready=0 for 4 cycles mid-stream → out_data stable, in_ready=0 during the stall, all 5 results correct and in order afterwards.
- Bubbles: in_valid toggles 1,0,1,0 → out_valid shows the same pattern shifted by 3 cycles, with correct data in the valid cycles.
- Reset mid-operation: 3 words in flight, drive rst_n=0 for 1 cycle → out_valid=0 and out_data=0 after the edge, no stale words emerge, next word correct after 3 cycles.
- Parameter sweep: N=2,4,16,32 with random data/amt/dir compared against a reference model: result = ((a<<s)|(a>>(N-s))) masked to N bits for left, mirrored for right.
